// File: rtl/ws2812_write_arbiter.sv
// ============================================================================
// ws2812_write_arbiter
// ----------------------------------------------------------------------------
// Arbitrates between two requesters (A = bit 0, B = bit 1) that update the
// colour memory of a WS2812 LED driver. Each request is either a single-LED
// write or a fill of the whole chain with one colour. Arbitration is
// round-robin, and the requester that was not granted last has priority.
// A fill is a burst of NUM_LEDS back-to-back write strobes. During the burst
// no further requests are accepted.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   req_valid  [1:0]  per-requester request valid
//   req_ready  [1:0]  per-requester accept (combinational)
//   req_fill   [1:0]  per-requester fill flag (1 = fill whole chain)
//   req_led_a/b       target LED index of a single write
//   req_rgb_a/b       colour, GRB order
//   wr_en             one-cycle write strobe to the driver
//   wr_led            LED index of the strobe (held when wr_en = 0)
//   wr_rgb            colour of the strobe (held when wr_en = 0)
//   busy              high on every strobe cycle of a fill burst
//   range_err         sticky: a single write with index >= NUM_LEDS was accepted
// ============================================================================
module ws2812_write_arbiter #(
    parameter int NUM_LEDS = 8,
    parameter int LED_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_fill,
    input  logic [LED_W-1:0] req_led_a,
    input  logic [LED_W-1:0] req_led_b,
    input  logic [23:0]      req_rgb_a,
    input  logic [23:0]      req_rgb_b,
    output logic             wr_en,
    output logic [LED_W-1:0] wr_led,
    output logic [23:0]      wr_rgb,
    output logic             busy,
    output logic             range_err
);

    localparam int               CNT_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_LEDS - 1);
    localparam logic [31:0]      NUM_LEDS_U = 32'(NUM_LEDS);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             prio_b;       // 1 = requester B has priority
    logic             prio_b_next;
    logic             sel_b;        // granted requester is B
    logic             transfer;
    logic [CNT_W-1:0] cnt;          // index of the next LED the fill writes
    logic             fill_last;

    logic             sel_fill;
    logic [LED_W-1:0] sel_led;
    logic [23:0]      sel_rgb;
    logic             sel_in_range;

    assign fill_last    = (cnt == CNT_LAST);
    assign sel_fill     = sel_b ? req_fill[1] : req_fill[0];
    assign sel_led      = sel_b ? req_led_b   : req_led_a;
    assign sel_rgb      = sel_b ? req_rgb_b   : req_rgb_a;
    assign sel_in_range = (32'(sel_led) < NUM_LEDS_U);

    // State and priority pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            prio_b <= 1'b0;
        end else begin
            state  <= state_next;
            prio_b <= prio_b_next;
        end
    end

    // Grant, next state and pointer update
    always_comb begin
        state_next  = state;
        prio_b_next = prio_b;
        req_ready   = 2'b00;
        sel_b       = 1'b0;
        transfer    = 1'b0;
        case (state)
            IDLE: begin
                // A lone requester wins regardless of the pointer.
                if (!reset && (req_valid != 2'b00)) begin
                    sel_b     = (req_valid == 2'b11) ? prio_b : req_valid[1];
                    req_ready = sel_b ? 2'b10 : 2'b01;
                    transfer  = 1'b1;
                end
                if (transfer) begin
                    prio_b_next = ~sel_b;
                    // A one-LED fill completes on its transfer edge.
                    if (sel_fill && (NUM_LEDS > 1)) begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                // Leave on the edge that presents the last LED, so the
                // next request can be taken while it is on the outputs.
                if (fill_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_led    <= '0;
            wr_rgb    <= '0;
            busy      <= 1'b0;
            range_err <= 1'b0;
            cnt       <= '0;
        end else begin
            wr_en <= 1'b0;
            busy  <= 1'b0;
            if (state == FILL) begin
                // wr_rgb already holds the fill colour from the transfer edge.
                wr_en  <= 1'b1;
                busy   <= 1'b1;
                wr_led <= LED_W'(cnt);
                if (!fill_last) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (transfer) begin
                if (sel_fill) begin
                    wr_en  <= 1'b1;
                    busy   <= 1'b1;
                    wr_led <= '0;
                    wr_rgb <= sel_rgb;
                    cnt    <= CNT_W'(1);
                end else if (sel_in_range) begin
                    wr_en  <= 1'b1;
                    wr_led <= sel_led;
                    wr_rgb <= sel_rgb;
                end else begin
                    range_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// ============================================================================
// tb_ws2812_write_arbiter
// ----------------------------------------------------------------------------
// Bench for ws2812_write_arbiter (NUM_LEDS = 8, LED_W = 8). A transaction
// model schedules every accepted request as a list of writes in a FIFO. One
// write leaves the FIFO per clock and that write is what the driver port must
// show. The arbiter may accept only while no further writes are queued.
// ============================================================================
module tb_ws2812_write_arbiter;

    localparam int NUM = 8;
    localparam int LW  = 8;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_fill;
    logic [LW-1:0] req_led_a;
    logic [LW-1:0] req_led_b;
    logic [23:0]   req_rgb_a;
    logic [23:0]   req_rgb_b;
    logic          wr_en;
    logic [LW-1:0] wr_led;
    logic [23:0]   wr_rgb;
    logic          busy;
    logic          range_err;

    ws2812_write_arbiter #(.NUM_LEDS(NUM), .LED_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fill  (req_fill),
        .req_led_a (req_led_a),
        .req_led_b (req_led_b),
        .req_rgb_a (req_rgb_a),
        .req_rgb_b (req_rgb_b),
        .wr_en     (wr_en),
        .wr_led    (wr_led),
        .wr_rgb    (wr_rgb),
        .busy      (busy),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] led;
        logic [23:0]   rgb;
        bit            fill;
    } wr_t;

    wr_t           q[$];
    bit            cur_en;
    logic [LW-1:0] cur_led;
    logic [23:0]   cur_rgb;
    bit            cur_fill;
    bit            m_rerr;
    bit            m_prio_b;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare outputs, drive inputs, compare ready, advance model.
    task automatic step(input bit rst, input logic [1:0] v, input logic [1:0] f,
                        input logic [LW-1:0] la, input logic [23:0] ra,
                        input logic [LW-1:0] lb, input logic [23:0] rb);
        logic [1:0]    eg;
        bit            sb;
        bit            fs;
        logic [LW-1:0] ls;
        logic [23:0]   rs;
        wr_t           w;
        @(negedge clk);
        check("wr_en", 32'(wr_en), 32'(cur_en));
        check("wr_led", 32'(wr_led), 32'(cur_led));
        check("wr_rgb", 32'(wr_rgb), 32'(cur_rgb));
        check("busy", 32'(busy), 32'(cur_en && cur_fill));
        check("range_err", 32'(range_err), 32'(m_rerr));
        reset     = rst;
        req_valid = v;
        req_fill  = f;
        req_led_a = la;
        req_rgb_a = ra;
        req_led_b = lb;
        req_rgb_b = rb;
        #1;
        eg = 2'b00;
        sb = 1'b0;
        if (!rst && (q.size() == 0) && (v != 2'b00)) begin
            sb = (v == 2'b11) ? m_prio_b : v[1];
            eg = sb ? 2'b10 : 2'b01;
        end
        check("req_ready", 32'(req_ready), 32'(eg));
        @(posedge clk);
        if (rst) begin
            q.delete();
            cur_en   = 1'b0;
            cur_led  = '0;
            cur_rgb  = '0;
            cur_fill = 1'b0;
            m_rerr   = 1'b0;
            m_prio_b = 1'b0;
        end else begin
            if (eg != 2'b00) begin
                m_prio_b = !sb;
                fs = sb ? f[1] : f[0];
                ls = sb ? lb : la;
                rs = sb ? rb : ra;
                if (fs) begin
                    for (int i = 0; i < NUM; i++) begin
                        w.led = LW'(i); w.rgb = rs; w.fill = 1'b1;
                        q.push_back(w);
                    end
                end else if (int'(ls) < NUM) begin
                    w.led = ls; w.rgb = rs; w.fill = 1'b0;
                    q.push_back(w);
                end else begin
                    m_rerr = 1'b1;
                end
            end
            if (q.size() > 0) begin
                w        = q.pop_front();
                cur_en   = 1'b1;
                cur_led  = w.led;
                cur_rgb  = w.rgb;
                cur_fill = w.fill;
            end else begin
                cur_en = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 2'b00; req_fill = 2'b00;
        req_led_a = '0; req_led_b = '0; req_rgb_a = '0; req_rgb_b = '0;
        cur_en = 1'b0; cur_led = '0; cur_rgb = '0; cur_fill = 1'b0;
        m_rerr = 1'b0; m_prio_b = 1'b0;

        // Reset state
        step(1, 2'b00, 2'b00, 0, 0, 0, 0);
        step(1, 2'b11, 2'b00, 1, 24'h1, 2, 24'h2);
        #2;
        check("lit_reset_wr_en", 32'(wr_en), 0);
        check("lit_reset_busy", 32'(busy), 0);
        check("lit_reset_rgb", 32'(wr_rgb), 0);

        // Single write from A
        step(0, 2'b01, 2'b00, 3, 24'h00FF00, 0, 0);
        #2;
        check("lit_single_en", 32'(wr_en), 1);
        check("lit_single_led", 32'(wr_led), 3);
        check("lit_single_rgb", 32'(wr_rgb), 32'h00FF00);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0);
        #2;
        check("lit_single_off", 32'(wr_en), 0);
        check("lit_single_hold", 32'(wr_led), 3);

        // Both requesters streaming singles alternate A,B,... after reset
        step(1, 2'b00, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 2'b11, 2'b00, 1, 24'hAA0000, 2, 24'h0000BB);
            #2;
            check("lit_rr_led", 32'(wr_led), (i % 2 == 0) ? 1 : 2);
        end

        // B fill while A waits with changing data
        step(1, 2'b00, 2'b00, 0, 0, 0, 0);
        step(0, 2'b10, 2'b10, 0, 0, 0, 24'h123456);
        for (int i = 0; i < 8; i++) begin
            step(0, 2'b01, 2'b00, 5, 24'h0A0000 + 24'(i), 0, 0);
            #2;
            if (i == 6) begin
                check("lit_fill_last_led", 32'(wr_led), 7);
                check("lit_fill_last_busy", 32'(busy), 1);
                check("lit_fill_last_rgb", 32'(wr_rgb), 32'h123456);
            end
            if (i == 7) begin
                check("lit_after_fill_led", 32'(wr_led), 5);
                check("lit_after_fill_rgb", 32'(wr_rgb), 32'h0A0007);
                check("lit_after_fill_busy", 32'(busy), 0);
            end
        end

        // Out-of-range single write sets the sticky error
        step(0, 2'b01, 2'b00, 8, 24'hFFFFFF, 0, 0);
        #2;
        check("lit_oor_en", 32'(wr_en), 0);
        check("lit_oor_err", 32'(range_err), 1);
        for (int i = 0; i < 4; i++) step(0, 2'b11, 2'b00, LW'(i), 24'h010101, 1, 24'h020202);
        #2;
        check("lit_oor_sticky", 32'(range_err), 1);

        // Reset in the middle of a fill
        step(0, 2'b10, 2'b10, 0, 0, 0, 24'h654321);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 2'b00, 0, 0, 0, 0);
        #2;
        check("lit_abort_led4", 32'(wr_led), 4);
        step(1, 2'b11, 2'b00, 0, 0, 0, 0);
        #2;
        check("lit_abort_en", 32'(wr_en), 0);
        check("lit_abort_busy", 32'(busy), 0);
        check("lit_abort_led", 32'(wr_led), 0);
        check("lit_abort_rgb", 32'(wr_rgb), 0);
        step(0, 2'b11, 2'b00, 2, 24'h111111, 6, 24'h222222);
        #2;
        check("lit_abort_prio_a", 32'(wr_led), 2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] f;
            f[0] = ($urandom_range(0, 7) == 0);
            f[1] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 99) == 0, 2'($urandom), f,
                 LW'($urandom_range(0, 9)), 24'($urandom),
                 LW'($urandom_range(0, 9)), 24'($urandom));
        end
        step(0, 2'b00, 2'b00, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
